mesh_port_arbiter: RTL

- Output-port controller for one terminal of a mesh router.
- Takes NUM_IN input FIFOs, each with a pndng/data/pop handshake.
- Decodes each head packet's destination against the router's position and the port direction.
- Grants one matching requester at a time in round-robin order and presents the packet to the downstream consumer through a one-entry output register.
- Instantiated once per output direction (N, S, E, W, local) inside each router of mesh_gnrtr.

---
 rtl/mesh_arb_pkg.sv | 56 +++++
 rtl/rr_pick.sv | 33 +++
 rtl/mesh_port_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mesh_arb_pkg.sv
// rtl/mesh_arb_pkg.sv - shared types, field offsets and route decode for the mesh port arbiter
//
// Contents:
//   dir_e          output direction served by a port (N, S, E, W, local)
//   STARVE_LIM     wait-count threshold used by the optional starvation override
//   *_msb/_bit     packet field positions as functions of the packet width
//   route_dir      dimension-ordered route decode for one head packet
package mesh_arb_pkg;

  typedef enum logic [2:0] {
    DIR_N     = 3'd0,
    DIR_S     = 3'd1,
    DIR_E     = 3'd2,
    DIR_W     = 3'd3,
    DIR_LOCAL = 3'd4
  } dir_e;

  localparam int STARVE_LIM = 16;
  localparam int WAIT_CNT_W = 8;

  function automatic int nxt_jump_msb(input int pckg_sz);
    return pckg_sz - 1;
  endfunction

  function automatic int dst_row_msb(input int pckg_sz);
    return pckg_sz - 9;
  endfunction

  function automatic int dst_col_msb(input int pckg_sz);
    return pckg_sz - 13;
  endfunction

  function automatic int mode_bit(input int pckg_sz);
    return pckg_sz - 17;
  endfunction

  // mode=1 resolves the row first, mode=0 the column first; a packet already
  // at its destination goes to the local port.
  function automatic dir_e route_dir(input logic [3:0] dst_row,
                                     input logic [3:0] dst_col,
                                     input logic       mode,
                                     input logic [3:0] id_row,
                                     input logic [3:0] id_col);
    dir_e row_dir;
    dir_e col_dir;
    row_dir = DIR_LOCAL;
    col_dir = DIR_LOCAL;
    if (dst_row < id_row)      row_dir = DIR_N;
    else if (dst_row > id_row) row_dir = DIR_S;
    if (dst_col < id_col)      col_dir = DIR_W;
    else if (dst_col > id_col) col_dir = DIR_E;
    if (mode) return (row_dir != DIR_LOCAL) ? row_dir : col_dir;
    else      return (col_dir != DIR_LOCAL) ? col_dir : row_dir;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority selector
//
// Ports:
//   req         in   NUM_IN  request vector
//   last_grant  in   IDX_W   index granted most recently; search starts one above it
//   winner      out  IDX_W   first requester found, wrapping modulo NUM_IN
//   any         out  1       at least one request is present
module rr_pick #(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  last_grant,
  output logic [IDX_W-1:0]  winner,
  output logic              any
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    pos    = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      pos = IDX_W'((int'(last_grant) + k) % NUM_IN);
      if (!any && req[pos]) begin
        any    = 1'b1;
        winner = pos;
      end
    end
  end

endmodule

// File: rtl/mesh_port_arbiter.sv
// rtl/mesh_port_arbiter.sv - round-robin output-port arbiter for one mesh router direction
//
// Ports:
//   clk          in   1               rising-edge clock
//   reset        in   1               asynchronous active-low reset
//   pndng_in     in   NUM_IN          input FIFO i has a head packet
//   data_in      in   NUM_IN*PCKG_SZ  head packets, slice i = [i*PCKG_SZ +: PCKG_SZ]
//   pop_out      out  NUM_IN          one-cycle pop to the granted input FIFO
//   data_out     out  PCKG_SZ         registered packet, nxt_jump rewritten to this router
//   pndng_out    out  1               data_out holds a valid packet
//   pop_in       in   1               downstream consumes data_out
//   grant_id     out  clog2(NUM_IN)   index of the most recent grant
//   starve_flag  out  1               (MESH_PORT_ARB_STARVE_EN only) some input waited STARVE_LIM cycles
//
// Build option: define MESH_PORT_ARB_STARVE_EN to add per-input wait counters
// that override round-robin for inputs that have waited too long.
module mesh_port_arbiter
  import mesh_arb_pkg::*;
#(
  parameter int PCKG_SZ   = 40,
  parameter int NUM_IN    = 4,
  parameter int ID_ROW    = 0,
  parameter int ID_COLUMN = 0,
  parameter int PORT_DIR  = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_IN-1:0]           pndng_in,
  input  logic [NUM_IN*PCKG_SZ-1:0]   data_in,
  output logic [NUM_IN-1:0]           pop_out,
  output logic [PCKG_SZ-1:0]          data_out,
  output logic                        pndng_out,
  input  logic                        pop_in,
  output logic [$clog2(NUM_IN)-1:0]   grant_id
`ifdef MESH_PORT_ARB_STARVE_EN
  ,
  output logic                        starve_flag
`endif
);

  localparam int IDX_W    = $clog2(NUM_IN);
  localparam int ROW_MSB  = dst_row_msb(PCKG_SZ);
  localparam int COL_MSB  = dst_col_msb(PCKG_SZ);
  localparam int MODE_BIT = mode_bit(PCKG_SZ);
  localparam int JMP_MSB  = nxt_jump_msb(PCKG_SZ);

  localparam logic [3:0] ROW_ID = ID_ROW[3:0];
  localparam logic [3:0] COL_ID = ID_COLUMN[3:0];
  localparam dir_e       MY_DIR = dir_e'(PORT_DIR[2:0]);

  // The nxt_jump rewrite is done with a mask so every packet bit stays in use.
  localparam logic [PCKG_SZ-1:0] JMP_MASK = {8'hFF, {(PCKG_SZ-8){1'b0}}};
  localparam logic [PCKG_SZ-1:0] JMP_VAL  = {ROW_ID, COL_ID, {(PCKG_SZ-8){1'b0}}};

  typedef enum logic {ST_IDLE, ST_VALID} state_e;

  state_e             state, state_nxt;
  logic [PCKG_SZ-1:0] pkt [NUM_IN];
  dir_e               dir [NUM_IN];
  logic [NUM_IN-1:0]  req;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   rr_win;
  logic               rr_any;
  logic [IDX_W-1:0]   win;
  logic               grant;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
    assign pkt[gi] = data_in[gi*PCKG_SZ +: PCKG_SZ];
    assign dir[gi] = route_dir(pkt[gi][ROW_MSB -: 4], pkt[gi][COL_MSB -: 4],
                               pkt[gi][MODE_BIT], ROW_ID, COL_ID);
    assign req[gi] = pndng_in[gi] && (dir[gi] == MY_DIR);
  end

  rr_pick #(.NUM_IN(NUM_IN), .IDX_W(IDX_W)) u_rr_pick (
    .req        (req),
    .last_grant (last_grant),
    .winner     (rr_win),
    .any        (rr_any)
  );

`ifdef MESH_PORT_ARB_STARVE_EN
  logic [WAIT_CNT_W-1:0] wait_cnt [NUM_IN];
  logic [NUM_IN-1:0]     over_lim;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_starve
    assign over_lim[gi] = wait_cnt[gi] >= WAIT_CNT_W'(STARVE_LIM);
  end

  assign starve_flag = |over_lim;

  // Descending scan so the lowest-index starved requester is the final pick.
  always_comb begin
    win = rr_win;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (over_lim[i] && req[i]) win = IDX_W'(i);
    end
  end

  // A counter with no pending request is cleared, so starve_flag only
  // reflects inputs that are actually still waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_IN; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (grant && (win == IDX_W'(i)))  wait_cnt[i] <= '0;
        else if (req[i])                  wait_cnt[i] <= (&wait_cnt[i]) ? wait_cnt[i] : wait_cnt[i] + 1'b1;
        else                              wait_cnt[i] <= '0;
      end
    end
  end
`else
  assign win = rr_win;
`endif

  // A grant happens whenever the output register is free this cycle: empty,
  // or being drained by pop_in, which gives zero-bubble back-to-back transfer.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rr_any) begin
          grant     = 1'b1;
          state_nxt = ST_VALID;
        end
      end
      ST_VALID: begin
        if (pop_in) begin
          if (rr_any) grant     = 1'b1;
          else        state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pop_out = '0;
    if (grant) pop_out[win] = 1'b1;
  end

  assign pndng_out = (state == ST_VALID);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      data_out   <= '0;
      grant_id   <= '0;
      last_grant <= IDX_W'(NUM_IN - 1);
    end else begin
      state <= state_nxt;
      if (grant) begin
        data_out   <= (pkt[win] & ~JMP_MASK) | JMP_VAL;
        grant_id   <= win;
        last_grant <= win;
      end
    end
  end

endmodule
